// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-address defaults for the scoreboard, decoder and regfile
package reg_scoreboard_pkg;
   localparam int AW_DEF    = 5;
   localparam int NREG_DEF  = 32;
   localparam int NRD_DEF   = 2;
   localparam int CNT_W_DEF = 2;
   typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating pending-write counter with one increment and two independent decrements
module sb_counter
   import reg_scoreboard_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_a_i,
   input  logic             dec_b_i,
   output logic [CNT_W-1:0] cnt_o
);
   localparam int CMAX = 2**CNT_W - 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   int net;
   // net change is -2..+1; clamp at both ends so a bad decrement cannot wrap
   always_comb begin
      net   = int'(cnt_q) + int'(inc_i) - int'(dec_a_i) - int'(dec_b_i);
      cnt_d = net < 0 ? '0 : net > CMAX ? CNT_W'(CMAX) : CNT_W'(net);
   end
   // counter register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   // decrementing an empty counter means the pipeline lost track of a writer
   always_ff @(posedge clk) begin
      if (!reset) assert (net >= 0) else $error("sb_counter underflow");
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters driving read hazards and the ID stall
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG      = NREG_DEF,
   parameter int AW        = AW_DEF,
   parameter int NRD       = NRD_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter bit WB_BYPASS = 1'b1
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [NRD-1:0]    rd_valid,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy,
   output logic            stall,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_addr,
   output logic            issue_ready,
   input  logic            retire_valid,
   input  logic [AW-1:0]   retire_addr,
   input  logic            cancel_valid,
   input  logic [AW-1:0]   cancel_addr,
   output logic            busy_any
);
   localparam logic [CNT_W-1:0] CMAX = '1;
   logic [CNT_W-1:0] cnt [2**AW];
   genvar r, p;
   // r0 and addresses past NREG have no counter and always read as idle
   for (r = 0; r < 2**AW; r++) begin : g_reg
      if (r > 0 && r < NREG) begin : g_cnt
         sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc_i   (issue_valid && issue_ready && issue_addr == AW'(r)),
            .dec_a_i (retire_valid && retire_addr == AW'(r)),
            .dec_b_i (cancel_valid && cancel_addr == AW'(r)),
            .cnt_o   (cnt[r])
         );
      end else begin : g_zero
         assign cnt[r] = '0;
      end
   end
   // a read is busy if writes remain pending after this cycle's cancel (and retire when bypassing)
   for (p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] a;
      logic [1:0]    dec;
      assign a          = rd_addr[p*AW +: AW];
      assign dec        = 2'(cancel_valid && cancel_addr == a) + 2'(WB_BYPASS && retire_valid && retire_addr == a);
      assign rd_busy[p] = rd_valid[p] && int'(cnt[a]) > int'(dec);
   end
   // a full counter only accepts another writer when one leaves in the same cycle
   always_comb begin
      issue_ready = cnt[issue_addr] != CMAX || (retire_valid && retire_addr == issue_addr) || (cancel_valid && cancel_addr == issue_addr);
      stall       = |rd_busy || (issue_valid && !issue_ready);
   end
   // drain indicator
   always_comb begin
      busy_any = 1'b0;
      for (int k = 0; k < 2**AW; k++) busy_any = busy_any || cnt[k] != '0;
   end
endmodule
